irq_rr_arbiter: RTL

IRQ_RR_ARBITER -- requirements
Module: irq_rr_arbiter

---
 rtl/irq_rr_arbiter_pkg.sv | 34 +++
 rtl/irq_rr_arbiter_onehot_enc8.sv | 17 +
 rtl/irq_rr_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/irq_rr_arbiter_pkg.sv
// Shared constants, types and helpers for the 8-input interrupt arbiter.
// Index i always refers to request bit (NREQ-1-i): bit 7 is index 0.
package irq_rr_arbiter_pkg;

   localparam int NREQ = 8;
   localparam int IDXW = 3;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   typedef logic [IDXW-1:0] idx_t;
   typedef logic [NREQ-1:0] vec_t;

   // Request-order vector with only the bit belonging to index i set.
   function automatic vec_t idx2vec(input idx_t i);
      vec_t v;
      v = '0;
      v[NREQ-1-int'(i)] = 1'b1;
      return v;
   endfunction

   // Request bits whose index has bit b set; used to build the encoder OR-trees.
   function automatic vec_t idx_bit_mask(input int b);
      vec_t m;
      m = '0;
      for (int p = 0; p < NREQ; p++) begin
         if ((((NREQ - 1 - p) >> b) & 1) == 1) begin
            m[p] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_rr_arbiter_onehot_enc8.sv
// One-hot to index encoder in request bit order: bit 7 -> 3'b000, bit 0 -> 3'b111.
// An all-zero input encodes to 3'b000.
module onehot_enc8
   import irq_rr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] onehot_i,
   output logic [IDXW-1:0] idx_o
);

   genvar gi;
   generate
      for (gi = 0; gi < IDXW; gi++) begin : g_bit
         assign idx_o[gi] = |(onehot_i & idx_bit_mask(gi));
      end
   endgenerate

endmodule

// File: rtl/irq_rr_arbiter.sv
// 8-input request arbiter with a pending register and a registered valid/ready grant.
// PRIO_MODE selects round-robin (rotating pointer) or fixed priority (bit 7 highest).
module irq_rr_arbiter
   import irq_rr_arbiter_pkg::*;
#(
   parameter int PRIO_MODE = PRIO_RR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic            grant_vld,
   input  logic            grant_rdy,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IDXW-1:0] grant_idx,
   output logic            busy
);

   vec_t pending_q, pending_d;
   idx_t ptr_q, ptr_d;
   logic grant_vld_q, grant_vld_d;
   vec_t grant_onehot_q, grant_onehot_d;
   idx_t grant_idx_q, grant_idx_d;

   vec_t            cand;
   logic [NREQ-1:0] cand_by_idx;
   idx_t            search_base;
   idx_t            win_idx;
   logic            win_found;
   vec_t            win_vec;
   idx_t            win_enc;
   logic            out_free;
   logic            accept;
   logic            load;

   assign cand     = pending_q | req;
   assign out_free = !grant_vld_q || grant_rdy;
   assign accept   = grant_vld_q && grant_rdy;
   assign load     = out_free && (|cand);

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rev
         assign cand_by_idx[gi] = cand[NREQ-1-gi];
      end

      // An accept at this edge advances the pointer, so the search already starts past it.
      if (PRIO_MODE == PRIO_FIXED) begin : g_fixed_base
         assign search_base = '0;
      end else begin : g_rr_base
         assign search_base = accept ? idx_t'(grant_idx_q + idx_t'(1)) : ptr_q;
      end
   endgenerate

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!win_found && cand_by_idx[idx_t'(search_base + idx_t'(j))]) begin
            win_found = 1'b1;
            win_idx   = idx_t'(search_base + idx_t'(j));
         end
      end
      win_vec = win_found ? idx2vec(win_idx) : '0;
   end

   onehot_enc8 u_enc (
      .onehot_i (win_vec),
      .idx_o    (win_enc)
   );

   always_comb begin
      pending_d      = pending_q | req;
      ptr_d          = ptr_q;
      grant_vld_d    = grant_vld_q;
      grant_onehot_d = grant_onehot_q;
      grant_idx_d    = grant_idx_q;

      // A held grant swallows a repeat of its own request instead of re-pending it.
      if (grant_vld_q && !grant_rdy) begin
         pending_d = pending_q | (req & ~grant_onehot_q);
      end else if (load) begin
         pending_d      = cand & ~win_vec;
         grant_vld_d    = 1'b1;
         grant_onehot_d = win_vec;
         grant_idx_d    = win_enc;
      end else if (out_free) begin
         grant_vld_d    = 1'b0;
         grant_onehot_d = '0;
         grant_idx_d    = '0;
      end

      if (PRIO_MODE == PRIO_RR && accept) begin
         ptr_d = idx_t'(grant_idx_q + idx_t'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q      <= '0;
         ptr_q          <= '0;
         grant_vld_q    <= 1'b0;
         grant_onehot_q <= '0;
         grant_idx_q    <= '0;
      end else begin
         pending_q      <= pending_d;
         ptr_q          <= ptr_d;
         grant_vld_q    <= grant_vld_d;
         grant_onehot_q <= grant_onehot_d;
         grant_idx_q    <= grant_idx_d;
      end
   end

   assign grant_vld    = grant_vld_q;
   assign grant_onehot = grant_onehot_q;
   assign grant_idx    = grant_idx_q;
   assign busy         = (|pending_q) || grant_vld_q;

endmodule
